// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one synchronous SRAM port between instruction fetch and data memory.
// DM has priority; a starvation counter forces an IF grant after STARVE_MAX consecutive DM wins.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic [3:0]        dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_DM = 1'b1} owner_t;

  localparam logic [2:0] LAT_LOAD   = 3'(RD_LAT);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      state_r, state_s;
  owner_t      owner_r, owner_s;
  logic [2:0]  lat_cnt_r, lat_cnt_s;
  logic [3:0]  starve_cnt_r, starve_cnt_s;
  logic        return_s;
  logic        eligible_s;
  logic        if_first_s;
  logic        rd_gnt_s;

  // Grant selection, read-data return and SRAM port drive.
  always_comb begin
    if_gnt     = 1'b0;
    dm_gnt     = 1'b0;
    if_rvalid  = 1'b0;
    dm_rvalid  = 1'b0;
    if_rdata   = {DATA_W{1'b0}};
    dm_rdata   = {DATA_W{1'b0}};
    mem_wen    = 4'b0000;
    mem_addr   = {ADDR_W{1'b0}};
    mem_wdata  = {DATA_W{1'b0}};
    // The return cycle of an outstanding read can also accept the next request.
    return_s   = (state_r == ST_WAIT) && (lat_cnt_r == 3'd1);
    eligible_s = !rst && ((state_r == ST_IDLE) || return_s);
    if_first_s = if_req && (starve_cnt_r == STARVE_LIM);

    if (eligible_s) begin
      if (if_first_s) begin
        if_gnt = 1'b1;
      end else if (dm_req) begin
        dm_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end else begin
        if_gnt = 1'b0;
      end
    end else begin
      if_gnt = 1'b0;
    end

    if (!rst && return_s) begin
      if (owner_r == OWN_DM) begin
        dm_rvalid = 1'b1;
        dm_rdata  = mem_rdata;
      end else begin
        if_rvalid = 1'b1;
        if_rdata  = mem_rdata;
      end
    end else begin
      if_rvalid = 1'b0;
    end

    mem_en = if_gnt | dm_gnt;
    if (dm_gnt) begin
      mem_wen   = dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
    end else begin
      mem_addr  = {ADDR_W{1'b0}};
    end

    busy = !rst && (state_r == ST_WAIT);
  end

  // Next-state: read tracking and starvation bookkeeping.
  always_comb begin
    state_s      = state_r;
    owner_s      = owner_r;
    lat_cnt_s    = lat_cnt_r;
    starve_cnt_s = starve_cnt_r;
    rd_gnt_s     = if_gnt | (dm_gnt & (dm_we == 4'b0000));

    if (rd_gnt_s) begin
      state_s   = ST_WAIT;
      lat_cnt_s = LAT_LOAD;
      owner_s   = dm_gnt ? OWN_DM : OWN_IF;
    end else begin
      case (state_r)
        ST_WAIT: begin
          if (lat_cnt_r <= 3'd1) begin
            state_s   = ST_IDLE;
            lat_cnt_s = 3'd0;
          end else begin
            lat_cnt_s = lat_cnt_r - 3'd1;
          end
        end
        ST_IDLE: begin
          state_s = ST_IDLE;
        end
        default: begin
          state_s   = ST_IDLE;
          lat_cnt_s = 3'd0;
        end
      endcase
    end

    // Only DM wins that cost a waiting fetch count towards starvation.
    if (if_gnt || !if_req) begin
      starve_cnt_s = 4'd0;
    end else if (dm_gnt && (starve_cnt_r < STARVE_LIM)) begin
      starve_cnt_s = starve_cnt_r + 4'd1;
    end else begin
      starve_cnt_s = starve_cnt_r;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      owner_r      <= OWN_IF;
      lat_cnt_r    <= 3'd0;
      starve_cnt_r <= 4'd0;
    end else begin
      state_r      <= state_s;
      owner_r      <= owner_s;
      lat_cnt_r    <= lat_cnt_s;
      starve_cnt_r <= starve_cnt_s;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: two arbiters (RD_LAT=1/STARVE_MAX=4 and RD_LAT=3/STARVE_MAX=2)
// driven from vector tables, with per-requester read-data scoreboards and SRAM models.
module tb_mem_port_arbiter;

  localparam logic [31:0] A_IF  = 32'hBFC0_0000;
  localparam logic [31:0] A_IF2 = 32'hBFC0_0004;
  localparam logic [31:0] A_DM  = 32'h0000_0100;
  localparam logic [31:0] A_DM2 = 32'h0000_0104;

  typedef struct {
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic [3:0]  dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        e_if_gnt;
    logic        e_dm_gnt;
    logic        e_if_rv;
    logic        e_dm_rv;
    logic        e_busy;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        dm_req = 1'b0;
  logic [3:0]  dm_we = 4'b0000;
  logic [31:0] dm_addr = 32'h0;
  logic [31:0] dm_wdata = 32'h0;

  logic        if_gnt1, if_rvalid1, dm_gnt1, dm_rvalid1, mem_en1, busy1;
  logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic [3:0]  mem_wen1;
  logic        if_gnt3, if_rvalid3, dm_gnt3, dm_rvalid3, mem_en3, busy3;
  logic [31:0] if_rdata3, dm_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
  logic [3:0]  mem_wen3;

  int checks = 0;
  int errors = 0;
  int cur_row = 0;
  logic [31:0] q_if1[$];
  logic [31:0] q_dm1[$];
  logic [31:0] q_if3[$];
  logic [31:0] q_dm3[$];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1), .STARVE_MAX(4)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt1), .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt1), .dm_rvalid(dm_rvalid1), .dm_rdata(dm_rdata1),
    .mem_en(mem_en1), .mem_wen(mem_wen1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .busy(busy1)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3), .STARVE_MAX(2)) dut3 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt3), .dm_rvalid(dm_rvalid3), .dm_rdata(dm_rdata3),
    .mem_en(mem_en3), .mem_wen(mem_wen3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .busy(busy3)
  );

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h2408_0001;
    return {a[15:0], a[31:16]} ^ 32'hA5A5_1234;
  endfunction

  // SRAM models: read data appears RD_LAT cycles after the enabled read.
  logic [31:0] pipe1;
  logic [31:0] pipe3 [0:2];
  always @(posedge clk) begin
    pipe1    <= (mem_en1 && mem_wen1 == 4'b0000) ? model_rd(mem_addr1) : 32'hDEAD_BEEF;
    pipe3[0] <= (mem_en3 && mem_wen3 == 4'b0000) ? model_rd(mem_addr3) : 32'hDEAD_BEEF;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign mem_rdata1 = pipe1;
  assign mem_rdata3 = pipe3[2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h want %h", nm, cur_row, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic ir, input logic [31:0] ia,
                              input logic dr, input logic [3:0] we, input logic [31:0] da,
                              input logic [31:0] wd, input logic eig, input logic edg,
                              input logic eiv, input logic edv, input logic eb);
    vec_t v;
    v.rst = r; v.if_req = ir; v.if_addr = ia; v.dm_req = dr; v.dm_we = we;
    v.dm_addr = da; v.dm_wdata = wd; v.e_if_gnt = eig; v.e_dm_gnt = edg;
    v.e_if_rv = eiv; v.e_dm_rv = edv; v.e_busy = eb;
    return v;
  endfunction

  task automatic apply(input vec_t v, input int idx, input bit use3);
    logic        ig, dg, iv, dv, bz, me;
    logic [3:0]  mw;
    logic [31:0] ma, mwd, ird, drd, e_addr;
    @(posedge clk); #1;
    rst = v.rst; if_req = v.if_req; if_addr = v.if_addr; dm_req = v.dm_req;
    dm_we = v.dm_we; dm_addr = v.dm_addr; dm_wdata = v.dm_wdata;
    if (v.e_if_gnt) begin
      if (use3) q_if3.push_back(model_rd(v.if_addr));
      else      q_if1.push_back(model_rd(v.if_addr));
    end
    if (v.e_dm_gnt && v.dm_we == 4'b0000) begin
      if (use3) q_dm3.push_back(model_rd(v.dm_addr));
      else      q_dm1.push_back(model_rd(v.dm_addr));
    end
    @(negedge clk);
    cur_row = idx;
    ig  = use3 ? if_gnt3    : if_gnt1;
    dg  = use3 ? dm_gnt3    : dm_gnt1;
    iv  = use3 ? if_rvalid3 : if_rvalid1;
    dv  = use3 ? dm_rvalid3 : dm_rvalid1;
    bz  = use3 ? busy3      : busy1;
    me  = use3 ? mem_en3    : mem_en1;
    mw  = use3 ? mem_wen3   : mem_wen1;
    ma  = use3 ? mem_addr3  : mem_addr1;
    mwd = use3 ? mem_wdata3 : mem_wdata1;
    ird = use3 ? if_rdata3  : if_rdata1;
    drd = use3 ? dm_rdata3  : dm_rdata1;
    e_addr = v.e_if_gnt ? v.if_addr : (v.e_dm_gnt ? v.dm_addr : 32'h0);
    chk("if_gnt",    32'(ig), 32'(v.e_if_gnt));
    chk("dm_gnt",    32'(dg), 32'(v.e_dm_gnt));
    chk("if_rvalid", 32'(iv), 32'(v.e_if_rv));
    chk("dm_rvalid", 32'(dv), 32'(v.e_dm_rv));
    chk("busy",      32'(bz), 32'(v.e_busy));
    chk("mem_en",    32'(me), 32'(v.e_if_gnt | v.e_dm_gnt));
    chk("mem_wen",   32'(mw), 32'(v.e_dm_gnt ? v.dm_we : 4'b0000));
    chk("mem_addr",  ma, e_addr);
    chk("mem_wdata", mwd, v.e_dm_gnt ? v.dm_wdata : 32'h0);
    if (iv) begin
      if (use3 && q_if3.size() > 0)       chk("if_rdata", ird, q_if3.pop_front());
      else if (!use3 && q_if1.size() > 0) chk("if_rdata", ird, q_if1.pop_front());
    end else begin
      chk("if_rdata_idle", ird, 32'h0);
    end
    if (dv) begin
      if (use3 && q_dm3.size() > 0)       chk("dm_rdata", drd, q_dm3.pop_front());
      else if (!use3 && q_dm1.size() > 0) chk("dm_rdata", drd, q_dm1.pop_front());
    end else begin
      chk("dm_rdata_idle", drd, 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v1[$];
    vec_t v3[$];
    int   lat_seen;
    logic [31:0] rd_seen;

    // RD_LAT=1, STARVE_MAX=4: rst ifr ifa dmr we dma wd | ifg dmg ifv dmv busy
    v1.push_back(mk(1'b1, 1'b1, A_IF,  1'b1, 4'h0, A_DM,  32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    v1.push_back(mk(1'b1, 1'b1, A_IF,  1'b1, 4'h0, A_DM,  32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    v1.push_back(mk(1'b1, 1'b1, A_IF,  1'b1, 4'h0, A_DM,  32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    v1.push_back(mk(1'b0, 1'b1, A_IF,  1'b1, 4'h0, A_DM,  32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    v1.push_back(mk(1'b0, 1'b1, A_IF,  1'b0, 4'h0, A_DM,  32'h0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1));
    v1.push_back(mk(1'b0, 1'b0, A_IF,  1'b0, 4'h0, A_DM,  32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
    v1.push_back(mk(1'b0, 1'b1, A_IF,  1'b0, 4'h0, A_DM,  32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    v1.push_back(mk(1'b0, 1'b0, A_IF,  1'b0, 4'h0, A_DM,  32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
    v1.push_back(mk(1'b0, 1'b0, A_IF,  1'b0, 4'h0, A_DM,  32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    v1.push_back(mk(1'b0, 1'b1, A_IF2, 1'b1, 4'hF, A_DM2, 32'h1111_1111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    v1.push_back(mk(1'b0, 1'b1, A_IF2, 1'b1, 4'hF, A_DM2, 32'h2222_2222, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    v1.push_back(mk(1'b0, 1'b1, A_IF2, 1'b1, 4'hF, A_DM2, 32'h3333_3333, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    v1.push_back(mk(1'b0, 1'b1, A_IF2, 1'b1, 4'hF, A_DM2, 32'h4444_4444, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    v1.push_back(mk(1'b0, 1'b1, A_IF2, 1'b1, 4'hF, A_DM2, 32'h5555_5555, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    v1.push_back(mk(1'b0, 1'b1, A_IF,  1'b1, 4'hF, A_DM2, 32'h5555_5555, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
    v1.push_back(mk(1'b0, 1'b1, A_IF,  1'b0, 4'h0, A_DM,  32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    v1.push_back(mk(1'b0, 1'b0, A_IF,  1'b0, 4'h0, A_DM,  32'h0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
    v1.push_back(mk(1'b0, 1'b0, A_IF,  1'b1, 4'h0, A_DM,  32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    v1.push_back(mk(1'b0, 1'b0, A_IF,  1'b1, 4'h0, A_DM2, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1));
    v1.push_back(mk(1'b0, 1'b0, A_IF,  1'b0, 4'h0, A_DM2, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    v1.push_back(mk(1'b0, 1'b0, A_IF,  1'b0, 4'h0, A_DM2, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    // RD_LAT=3, STARVE_MAX=2
    v3.push_back(mk(1'b1, 1'b0, A_IF,  1'b0, 4'h0, A_DM,  32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    v3.push_back(mk(1'b0, 1'b0, A_IF,  1'b1, 4'h0, A_DM,  32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    v3.push_back(mk(1'b0, 1'b0, A_IF,  1'b1, 4'h0, A_DM2, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    v3.push_back(mk(1'b0, 1'b0, A_IF,  1'b1, 4'h0, A_DM2, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    v3.push_back(mk(1'b0, 1'b0, A_IF,  1'b1, 4'h0, A_DM2, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1));
    v3.push_back(mk(1'b0, 1'b0, A_IF,  1'b0, 4'h0, A_DM2, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    v3.push_back(mk(1'b0, 1'b0, A_IF,  1'b0, 4'h0, A_DM2, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    v3.push_back(mk(1'b0, 1'b0, A_IF,  1'b0, 4'h0, A_DM2, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    v3.push_back(mk(1'b0, 1'b0, A_IF,  1'b0, 4'h0, A_DM2, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    v3.push_back(mk(1'b0, 1'b1, A_IF,  1'b1, 4'h3, A_DM,  32'h0000_A5A5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    v3.push_back(mk(1'b0, 1'b1, A_IF,  1'b1, 4'h3, A_DM,  32'h0000_5A5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    v3.push_back(mk(1'b0, 1'b1, A_IF,  1'b1, 4'h3, A_DM,  32'h0000_C3C3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    v3.push_back(mk(1'b0, 1'b0, A_IF,  1'b1, 4'h3, A_DM,  32'h0000_C3C3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    v3.push_back(mk(1'b0, 1'b0, A_IF,  1'b1, 4'h3, A_DM,  32'h0000_C3C3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    v3.push_back(mk(1'b0, 1'b0, A_IF,  1'b1, 4'h3, A_DM,  32'h0000_C3C3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
    v3.push_back(mk(1'b0, 1'b0, A_IF,  1'b0, 4'h0, A_DM,  32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    for (int i = 0; i < v1.size(); i++) apply(v1[i], i, 1'b0);
    for (int i = 0; i < v3.size(); i++) apply(v3[i], 100 + i, 1'b1);

    // Reset while a 3-cycle DM read is outstanding: the read must vanish.
    @(posedge clk); #1;
    rst = 1'b0; if_req = 1'b1; if_addr = A_IF; dm_req = 1'b1; dm_we = 4'b0000; dm_addr = A_DM;
    @(negedge clk); cur_row = 200;
    chk("t6_dm_gnt", 32'(dm_gnt3), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk); cur_row = 201;
    chk("t6_starve_pre", 32'(dut3.starve_cnt_r), 32'h1);
    chk("t6_rst_gnt",    32'({if_gnt3, dm_gnt3, mem_en3}), 32'h0);
    chk("t6_rst_busy",   32'(busy3), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; if_req = 1'b0; dm_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); cur_row = 210 + k;
      chk("t6_no_rvalid", 32'({if_rvalid3, dm_rvalid3}), 32'h0);
      chk("t6_busy",      32'(busy3), 32'h0);
      chk("t6_starve",    32'(dut3.starve_cnt_r), 32'h0);
      @(posedge clk); #1;
    end

    // Bounded wait for a fresh RD_LAT=3 read after reset.
    dm_req = 1'b1; dm_we = 4'b0000; dm_addr = A_DM2;
    @(negedge clk); cur_row = 300;
    chk("t7_dm_gnt", 32'(dm_gnt3), 32'h1);
    @(posedge clk); #1;
    dm_req = 1'b0;
    lat_seen = 0;
    rd_seen  = 32'h0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (dm_rvalid3) begin
        lat_seen = k;
        rd_seen  = dm_rdata3;
        break;
      end
    end
    cur_row = 301;
    chk("t7_latency", 32'(lat_seen), 32'd3);
    chk("t7_rdata",   rd_seen, model_rd(A_DM2));

    chk("queues_drained", 32'(q_if1.size() + q_dm1.size() + q_if3.size() + q_dm3.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
